// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: FSM state encoding, port IDs, default widths.
package ram_arb_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 32;
    localparam int HOLD_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-port winner select: round-robin with owner lock, or fixed priority under RAM_ARB_FIXED_PRIO_EN.
// Purely combinational; no backpressure of its own, it only names a winner when a request is present.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_lock0,
    input  logic i_lock1,
    input  logic i_last_owner,
    input  logic i_hold_lim,
    output logic o_winner,
    output logic o_vld
);

    assign o_vld = i_req0 | i_req1;

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic w_unused;
    assign w_unused = ^{i_lock0, i_lock1, i_last_owner, i_hold_lim};
    assign o_winner = i_req0 ? PORT0 : PORT1;
`else
    // The last owner keeps the grant while it locks, until the hold limit lets the other port in.
    logic w_keep;
    assign w_keep = ((i_last_owner == PORT0) ? i_lock0 : i_lock1) & ~i_hold_lim;

    always_comb begin
        o_winner = i_req0 ? PORT0 : PORT1;
        if (i_req0 && i_req1) begin
            o_winner = w_keep ? i_last_owner : ~i_last_owner;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-master single-port RAM arbiter, IDLE->ACCESS->RESP, ACK two cycles after the IDLE grant.
// Masters hold REQ until ACK; RAM strobes only in ACCESS. Define RAM_ARB_FIXED_PRIO_EN for fixed priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic              iRAM_CLK,
    input  logic              iRAM_RST,
    input  logic              iM0_REQ,
    input  logic              iM0_WR,
    input  logic              iM0_LOCK,
    input  logic [ADDR_W-1:0] iM0_ADDR,
    input  logic [DATA_W-1:0] iM0_WDATA,
    output logic              oM0_ACK,
    output logic [DATA_W-1:0] oM0_RDATA,
    input  logic              iM1_REQ,
    input  logic              iM1_WR,
    input  logic              iM1_LOCK,
    input  logic [ADDR_W-1:0] iM1_ADDR,
    input  logic [DATA_W-1:0] iM1_WDATA,
    output logic              oM1_ACK,
    output logic [DATA_W-1:0] oM1_RDATA,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic              oRAM_WR,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    output logic [DATA_W-1:0] oRAM_DATA,
    input  logic [DATA_W-1:0] iRAM_DATA
);

    state_t              r_state;
    state_t              w_next;
    logic                r_owner;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                w_win;
    logic                w_vld;
    logic                w_grant;
    logic                w_hold_lim;

    ram_arb_rr u_rr (
        .i_req0       (iM0_REQ),
        .i_req1       (iM1_REQ),
        .i_lock0      (iM0_LOCK),
        .i_lock1      (iM1_LOCK),
        .i_last_owner (r_owner),
        .i_hold_lim   (w_hold_lim),
        .o_winner     (w_win),
        .o_vld        (w_vld)
    );

    assign w_grant = (r_state == IDLE) && w_vld;

    always_ff @(posedge iRAM_CLK or negedge iRAM_RST) begin
        if (!iRAM_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_vld ? ACCESS : IDLE;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Strobes decode straight from the async-reset state so a reset in ACCESS drops them at once.
    always_comb begin
        oRAM_CE = 1'b0;
        oRAM_RD = 1'b0;
        oRAM_WR = 1'b0;
        oM0_ACK = 1'b0;
        oM1_ACK = 1'b0;
        if (r_state == ACCESS) begin
            oRAM_CE = 1'b1;
            oRAM_RD = ~r_wr;
            oRAM_WR = r_wr;
        end
        if (r_state == RESP) begin
            oM0_ACK = (r_owner == PORT0);
            oM1_ACK = (r_owner == PORT1);
        end
    end

    assign oRAM_ADDR = r_addr;
    assign oRAM_DATA = r_wdata;
    assign oM0_RDATA = r_rdata0;
    assign oM1_RDATA = r_rdata1;

    // Owner resets to PORT1 so the first contested arbitration favours port 0.
    always_ff @(posedge iRAM_CLK or negedge iRAM_RST) begin
        if (!iRAM_RST) begin
            r_owner  <= PORT1;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= w_win;
                r_wr    <= (w_win == PORT1) ? iM1_WR    : iM0_WR;
                r_addr  <= (w_win == PORT1) ? iM1_ADDR  : iM0_ADDR;
                r_wdata <= (w_win == PORT1) ? iM1_WDATA : iM0_WDATA;
            end
            if ((r_state == ACCESS) && !r_wr) begin
                if (r_owner == PORT0) begin
                    r_rdata0 <= iRAM_DATA;
                end else begin
                    r_rdata1 <= iRAM_DATA;
                end
            end
        end
    end

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign w_hold_lim = 1'b0;
`else
    localparam int                CNT_W    = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0]  HOLD_LIM = CNT_W'(HOLD_MAX);

    logic [CNT_W-1:0] r_cnt;

    // Counts consecutive grants to the same owner, saturating at the hold limit.
    always_ff @(posedge iRAM_CLK or negedge iRAM_RST) begin
        if (!iRAM_RST) begin
            r_cnt <= '0;
        end else if (w_grant) begin
            if (w_win != r_owner) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != HOLD_LIM) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_hold_lim = (r_cnt == HOLD_LIM);
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level reference model feeds expected ACK/RAM-op queues,
// a negedge monitor pops and compares whenever the DUT presents an ACK or a RAM strobe.
module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int HM = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req, wr, lock;
    logic [AW-1:0]   addr  [2];
    logic [DW-1:0]   wdata [2];
    logic [1:0]      ack;
    logic [DW-1:0]   rdata0, rdata1;
    logic            ram_ce, ram_rd, ram_wr;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdat, ram_rdat;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(HM)) dut (
        .iRAM_CLK  (clk),
        .iRAM_RST  (rst_n),
        .iM0_REQ   (req[0]),
        .iM0_WR    (wr[0]),
        .iM0_LOCK  (lock[0]),
        .iM0_ADDR  (addr[0]),
        .iM0_WDATA (wdata[0]),
        .oM0_ACK   (ack[0]),
        .oM0_RDATA (rdata0),
        .iM1_REQ   (req[1]),
        .iM1_WR    (wr[1]),
        .iM1_LOCK  (lock[1]),
        .iM1_ADDR  (addr[1]),
        .iM1_WDATA (wdata[1]),
        .oM1_ACK   (ack[1]),
        .oM1_RDATA (rdata1),
        .oRAM_CE   (ram_ce),
        .oRAM_RD   (ram_rd),
        .oRAM_WR   (ram_wr),
        .oRAM_ADDR (ram_addr),
        .oRAM_DATA (ram_wdat),
        .iRAM_DATA (ram_rdat)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // RAM behind the arbiter: synchronous write, combinational read.
    logic [DW-1:0] ram [256];
    bit            ram_inited = 1'b0;
    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ram_inited <= 1'b1;
        end else if (ram_ce && ram_wr) begin
            ram[ram_addr] <= ram_wdat;
        end
    end
    assign ram_rdat = ram[ram_addr];

    // Reference model: one transaction per arbitration slot, slots at least 3 cycles apart.
    typedef struct { int cyc; logic [DW-1:0] rd; } ack_t;
    typedef struct { int cyc; logic w; logic [AW-1:0] a; logic [DW-1:0] d; } ramop_t;

    ack_t    ack_q0[$];
    ack_t    ack_q1[$];
    ramop_t  ram_q[$];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] last_rd [2];
    bit      ref_inited = 1'b0;
    int      last_own = 1;
    int      grants = 0;
    int      next_free = 0;
    int      mw;
    bit      pend_vld = 1'b0;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;

    always @(posedge clk) begin
        cyc++;
        if (!ref_inited) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            ref_inited = 1'b1;
        end
        if (!rst_n) begin
            last_own = 1; grants = 0; next_free = 0; pend_vld = 1'b0;
            last_rd[0] = '0; last_rd[1] = '0;
            ack_q0.delete(); ack_q1.delete(); ram_q.delete();
        end else begin
            if (pend_vld) begin
                ref_mem[pend_a] = pend_d;
                pend_vld = 1'b0;
            end
            if (cyc >= next_free && req != 2'b00) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                mw = req[0] ? 0 : 1;
`else
                if (req == 2'b11)
                    mw = (lock[last_own] && grants < HM) ? last_own : 1 - last_own;
                else
                    mw = req[0] ? 0 : 1;
                grants = (mw == last_own) ? ((grants < HM) ? grants + 1 : grants) : 1;
`endif
                last_own = mw;
                ram_q.push_back('{cyc, wr[mw], addr[mw], wdata[mw]});
                if (wr[mw]) begin
                    pend_vld = 1'b1; pend_a = addr[mw]; pend_d = wdata[mw];
                end else begin
                    last_rd[mw] = ref_mem[addr[mw]];
                end
                if (mw == 0) ack_q0.push_back('{cyc + 1, last_rd[0]});
                else         ack_q1.push_back('{cyc + 1, last_rd[1]});
                next_free = cyc + 3;
            end
        end
    end

    ack_t   fa;
    ramop_t fr;
    bit     have;

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            have = (p == 0) ? (ack_q0.size() != 0) : (ack_q1.size() != 0);
            if (have) begin
                if (p == 0) fa = ack_q0[0]; else fa = ack_q1[0];
            end
            if (ack[p]) begin
                if (!have) begin
                    chk($sformatf("m%0d_ack_unexpected", p), 64'(ack[p]), 64'd0);
                end else begin
                    if (p == 0) void'(ack_q0.pop_front()); else void'(ack_q1.pop_front());
                    chk($sformatf("m%0d_ack_cycle", p), 64'(cyc), 64'(fa.cyc));
                    chk($sformatf("m%0d_rdata", p), 64'((p == 0) ? rdata0 : rdata1), 64'(fa.rd));
                end
            end else if (have && fa.cyc <= cyc) begin
                if (p == 0) void'(ack_q0.pop_front()); else void'(ack_q1.pop_front());
                chk($sformatf("m%0d_ack_missing", p), 64'(ack[p]), 64'd1);
            end
        end
        if (ram_ce) begin
            if (ram_q.size() == 0) begin
                chk("ram_ce_unexpected", 64'(ram_ce), 64'd0);
            end else begin
                fr = ram_q.pop_front();
                chk("ram_cycle", 64'(cyc), 64'(fr.cyc));
                chk("ram_wr", 64'(ram_wr), 64'(fr.w));
                chk("ram_rd", 64'(ram_rd), 64'(!fr.w));
                chk("ram_addr", 64'(ram_addr), 64'(fr.a));
                chk("ram_data", 64'(ram_wdat), 64'(fr.d));
            end
        end else begin
            chk("ram_idle_strobes", 64'({ram_rd, ram_wr}), 64'd0);
            if (ram_q.size() != 0 && ram_q[0].cyc <= cyc) begin
                void'(ram_q.pop_front());
                chk("ram_access_missing", 64'(ram_ce), 64'd1);
            end
        end
    end

    task automatic do_txn(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic lk);
        int t = 0;
        wr[p] = w; addr[p] = a; wdata[p] = d; lock[p] = lk; req[p] = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!ack[p] && t < 200);
        if (!ack[p]) chk($sformatf("m%0d_ack_wait", p), 64'(ack[p]), 64'd1);
    endtask

    // lmode: 0 random lock, 1 always lock, 2 never lock; cont keeps REQ high between transactions.
    task automatic run_master(input int p, input int n, input int lmode, input bit cont);
        logic lk;
        for (int i = 0; i < n; i++) begin
            lk = (lmode == 1) ? 1'b1 : (lmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            do_txn(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 20)), $urandom, lk);
            if (!cont && $urandom_range(0, 1) == 1) begin
                req[p] = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        req[p] = 1'b0;
    endtask

    initial begin
        int t;
        rst_n = 1'b0; req = '0; wr = '0; lock = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        repeat (3) @(negedge clk);
        chk("rst_ce",    64'(ram_ce),   64'd0);
        chk("rst_rdwr",  64'({ram_rd, ram_wr}), 64'd0);
        chk("rst_addr",  64'(ram_addr), 64'd0);
        chk("rst_data",  64'(ram_wdat), 64'd0);
        chk("rst_ack",   64'(ack),      64'd0);
        chk("rst_rdata0", 64'(rdata0),  64'd0);
        chk("rst_rdata1", 64'(rdata1),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
        req[0] = 1'b0;
        do_txn(1, 1'b0, 8'h10, 32'h0, 1'b0);
        chk("m1_read_deadbeef", 64'(rdata1), 64'hDEADBEEF);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);

        fork
            run_master(0, 10, 2, 1'b1);
            run_master(1, 10, 2, 1'b1);
        join
        repeat (3) @(negedge clk);
        fork
            run_master(0, 20, 1, 1'b1);
            run_master(1, 5, 2, 1'b1);
        join
        repeat (3) @(negedge clk);
        fork
            run_master(0, 30, 0, 1'b0);
            run_master(1, 30, 0, 1'b0);
        join
        repeat (3) @(negedge clk);

        // Reset in the middle of a write ACCESS.
        wr[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 32'hCAFEF00D; lock[0] = 1'b0; req[0] = 1'b1;
        t = 0;
        while (!ram_wr && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("abort_wr_seen", 64'(ram_wr), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("abort_wr_async", 64'(ram_wr), 64'd0);
        chk("abort_ce_async", 64'(ram_ce), 64'd0);
        req[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_ack", 64'(ack), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_after", 64'({ram_ce, ack}), 64'd0);
        chk("abort_no_commit", 64'(ram[8'h20]), 64'(init_val(32)));
        do_txn(0, 1'b0, 8'h20, 32'h0, 1'b0);
        req[0] = 1'b0;
        chk("abort_readback", 64'(rdata0), 64'(init_val(32)));

        // Request present at the very release of reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1, 1'b1, 8'h05, 32'h12345678, 1'b0);
        req[1] = 1'b0;
        repeat (4) @(negedge clk);

        chk("ack_q0_drained", 64'(ack_q0.size()), 64'd0);
        chk("ack_q1_drained", 64'(ack_q1.size()), 64'd0);
        chk("ram_q_drained",  64'(ram_q.size()),  64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter HOLD_MAX, default 4, max consecutive grants kept by a locking port while the other port waits.
REQ-004 SHALL have port iRAM_CLK  input  1  clock, all state on rising edge.
REQ-005 SHALL have port iRAM_RST  input  1  asynchronous reset, active-low.
REQ-006 SHALL have, for x in {0,1}, iMx_REQ  input  1  access request, held high until ack.
REQ-007 SHALL have iMx_WR  input  1  1 = write, 0 = read; iMx_LOCK  input  1  keep grant for back-to-back accesses.
REQ-008 SHALL have iMx_ADDR  input  ADDR_W  and iMx_WDATA  input  DATA_W  request address/write data, stable while REQ high.
REQ-009 SHALL have oMx_ACK  output  1  one-cycle completion pulse; oMx_RDATA  output  DATA_W  read data, valid with ACK.
REQ-010 SHALL have RAM-side oRAM_CE, oRAM_RD, oRAM_WR  output  1 each; oRAM_ADDR  output  ADDR_W; oRAM_DATA  output  DATA_W  write data; iRAM_DATA  input  DATA_W  combinational RAM read data.

Function
REQ-011 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction per 3 cycles.
REQ-012 In IDLE with any REQ high, SHALL pick a winner, register owner/WR/ADDR/WDATA, go to ACCESS next cycle; no REQ -> stay IDLE.
REQ-013 In ACCESS SHALL drive oRAM_CE=1, oRAM_RD=~WR, oRAM_WR=WR, oRAM_ADDR/oRAM_DATA from registers; all RAM strobes 0 in every other state.
REQ-014 Write SHALL commit at the rising edge ending ACCESS; read SHALL capture iRAM_DATA into owner's RDATA register at that edge.
REQ-015 In RESP SHALL pulse owner's oMx_ACK for exactly one cycle; other port's ACK 0; request-to-ACK latency 2 cycles from IDLE sampling.
REQ-016 oMx_RDATA SHALL hold its last captured value until the next read by that port; writes leave it unchanged.
REQ-017 Default arbitration: 2-way round-robin; on simultaneous REQ the port not served last wins; single requester always wins.
REQ-018 If last owner has LOCK=1 and REQ=1 in IDLE, it SHALL win regardless of round-robin, up to HOLD_MAX consecutive grants.
REQ-019 Consecutive-grant counter SHALL reset on owner change; at HOLD_MAX with other port requesting, lock SHALL be ignored for that arbitration; with other port idle, lock grants continue unbounded.
REQ-020 REQ dropped before ACK SHALL be a protocol violation; a transaction already in ACCESS SHALL still complete and ACK.

Reset
REQ-021 While iRAM_RST=0: state IDLE, oRAM_CE/RD/WR=0, oRAM_ADDR=0, oRAM_DATA=0, oMx_ACK=0, oMx_RDATA=0, round-robin pointer favours port 0, grant counter 0.
REQ-022 Reset asserted during ACCESS SHALL drop oRAM_WR immediately (asynchronous); the transaction is aborted with no ACK.
REQ-023 First arbitration after reset release SHALL occur at the first rising edge with iRAM_RST=1.

Configuration
REQ-024 With RAM_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (port 0 always wins simultaneous requests) and LOCK/HOLD_MAX logic SHALL be absent (LOCK ignored).
REQ-025 Without RAM_ARB_FIXED_PRIO_EN, REQ-017..REQ-019 apply.

Structure
REQ-026 Package ram_arb_pkg SHALL hold FSM state encodings (IDLE, ACCESS, RESP), port IDs (PORT0, PORT1) and default widths.
REQ-027 Winner selection SHALL be in sub-module ram_arb_rr (inputs: two requests, two locks, last owner, hold-limit flag; output: winner, valid).

Verification
REQ-028 Reset then M0 write ADDR=0x10 WDATA=0xDEADBEEF -> oRAM_WR=1, oRAM_ADDR=0x10 in ACCESS; oM0_ACK pulse 2 cycles after request.
REQ-029 M1 read ADDR=0x10 after REQ-028 -> oRAM_RD=1 one cycle, oM1_RDATA=0xDEADBEEF with oM1_ACK.
REQ-030 M0 and M1 request continuously from reset -> grants alternate 0,1,0,1; each ACK every 6 cycles.
REQ-031 M0 LOCK=1 with continuous REQ, M1 requesting, HOLD_MAX=4 -> four M0 grants then one M1 grant.
REQ-032 Assert iRAM_RST mid-ACCESS of a write -> oRAM_WR falls same cycle, no ACK, FSM IDLE after release.
REQ-033 RAM_ARB_FIXED_PRIO_EN defined, both requesting continuously -> M0 granted every time, M1 starved.
